// File: rtl/jpeg_quantizer_stream.sv
// Streaming 8x8-block quantizer: coef * reciprocal, round half away from zero, saturate.
// Define JPQ_NZ_STATS_EN to enable the per-block non-zero output counter on nz_count.
module jpeg_quantizer_stream #(
  parameter int unsigned IN_W       = 11,
  parameter int unsigned OUT_W      = 11,
  parameter int unsigned RECIP_W    = 13,
  parameter int unsigned FRAC       = 12,
  parameter int unsigned NUM_TABLES = 3,
  localparam int unsigned TSEL_W    = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_W-1:0]     in_data,
  input  logic        [TSEL_W-1:0]   in_tsel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_last,
  input  logic                       tbl_wr_en,
  input  logic        [TSEL_W-1:0]   tbl_wr_sel,
  input  logic        [5:0]          tbl_wr_addr,
  input  logic        [RECIP_W-1:0]  tbl_wr_data,
  output logic        [6:0]          nz_count
);

  localparam int unsigned PROD_W = IN_W + RECIP_W + 1;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam int unsigned HALF   = 2 ** (FRAC - 1);
  localparam int unsigned MAXP   = 2 ** (OUT_W - 1) - 1;
  localparam int unsigned MAXN   = 2 ** (OUT_W - 1);

  logic [RECIP_W-1:0] tbl [NUM_TABLES][64];

  logic               advance;
  logic [5:0]         in_idx;
  logic [TSEL_W-1:0]  blk_tsel;
  logic [TSEL_W-1:0]  sel_in_c;
  logic [TSEL_W-1:0]  lk_sel_c;
  logic               wr_ok_c;

  logic                      s1_valid;
  logic signed [IN_W-1:0]    s1_coef;
  logic [5:0]                s1_idx;
  logic [RECIP_W-1:0]        s1_recip;
  logic                      s2_valid;
  logic signed [PROD_W-1:0]  s2_prod;
  logic [5:0]                s2_idx;

  logic                      neg_c;
  logic [PROD_W-1:0]         prod_u_c;
  logic [PROD_W-1:0]         mag_c;
  logic [SUM_W-1:0]          rnd_c;
  logic signed [OUT_W-1:0]   q_c;

  // Single global advance: every stage moves together or holds together.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Out-of-range selects fall back to table 0; the block's table is latched at index 0.
  assign sel_in_c = (32'(in_tsel) < NUM_TABLES) ? in_tsel : '0;
  assign lk_sel_c = (in_idx == 6'd0) ? sel_in_c : blk_tsel;
  assign wr_ok_c  = tbl_wr_en && (32'(tbl_wr_sel) < NUM_TABLES);

  // Reciprocal tables; lookups read the pre-write value on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned t = 0; t < NUM_TABLES; t++) begin
        for (int unsigned a = 0; a < 64; a++) begin
          tbl[t][a] <= RECIP_W'(2 ** FRAC);
        end
      end
    end else if (wr_ok_c) begin
      tbl[tbl_wr_sel][tbl_wr_addr] <= tbl_wr_data;
    end
  end

  // Rounding on magnitude, then sign reapplied and result clamped.
  always_comb begin
    prod_u_c = s2_prod;
    neg_c    = s2_prod[PROD_W-1];
    mag_c    = neg_c ? (~prod_u_c + PROD_W'(1)) : prod_u_c;
    rnd_c    = ({1'b0, mag_c} + SUM_W'(HALF)) >> FRAC;
    q_c      = '0;
    if (!neg_c) begin
      q_c = (rnd_c > SUM_W'(MAXP)) ? OUT_W'(MAXP) : OUT_W'(rnd_c);
    end else begin
      q_c = (rnd_c > SUM_W'(MAXN)) ? OUT_W'(MAXN) : OUT_W'(SUM_W'(0) - rnd_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx    <= '0;
      blk_tsel  <= '0;
      s1_valid  <= 1'b0;
      s1_coef   <= '0;
      s1_idx    <= '0;
      s1_recip  <= '0;
      s2_valid  <= 1'b0;
      s2_prod   <= '0;
      s2_idx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_coef  <= in_data;
        s1_idx   <= in_idx;
        s1_recip <= tbl[lk_sel_c][in_idx];
        in_idx   <= in_idx + 6'd1;
        if (in_idx == 6'd0) blk_tsel <= sel_in_c;
      end
      s2_valid  <= s1_valid;
      s2_prod   <= PROD_W'(s1_coef) * PROD_W'($signed({1'b0, s1_recip}));
      s2_idx    <= s1_idx;
      out_valid <= s2_valid;
      out_last  <= s2_valid && (s2_idx == 6'd63);
      if (s2_valid) out_data <= q_c;
    end
  end

`ifdef JPQ_NZ_STATS_EN
  logic [6:0] nz_acc;
  logic [6:0] nz_next;

  assign nz_next = nz_acc + 7'(out_data != '0);

  // Count accepted non-zero outputs; publish and clear when the block's last one leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      nz_acc   <= '0;
      nz_count <= '0;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        nz_count <= nz_next;
        nz_acc   <= '0;
      end else begin
        nz_acc <= nz_next;
      end
    end
  end
`else
  assign nz_count = '0;
`endif

endmodule

// File: tb/tb_jpeg_quantizer_stream.sv
// Bench for jpeg_quantizer_stream: directed + randomized blocks against an arithmetic reference model.
module tb_jpeg_quantizer_stream;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [10:0] in_data;
  logic [1:0]         in_tsel;
  logic               out_valid;
  logic               out_ready;
  logic signed [10:0] out_data;
  logic               out_last;
  logic               tbl_wr_en;
  logic [1:0]         tbl_wr_sel;
  logic [5:0]         tbl_wr_addr;
  logic [12:0]        tbl_wr_data;
  logic [6:0]         nz_count;

  int checks = 0;
  int errors = 0;
  int rd = 0;

  int exp_d[$];
  bit exp_l[$];
  int obs_d[$];
  bit obs_l[$];

  int m_idx = 0;
  int m_tsel = 0;
  int tbl_m[3][64];

  always #5 clk = ~clk;

  jpeg_quantizer_stream dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tsel(in_tsel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_sel(tbl_wr_sel), .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_data(tbl_wr_data), .nz_count(nz_count)
  );

  // Quantize: round |coef*recip| / 4096 half away from zero, reapply sign, clamp to 11 bits.
  function automatic int qref(input int c, input int r);
    longint p, m, q;
    p = longint'(c) * longint'(r);
    m = (p < 0) ? -p : p;
    q = (m + 2048) / 4096;
    if (p < 0) q = -q;
    if (q > 1023) q = 1023;
    if (q < -1024) q = -1024;
    return int'(q);
  endfunction

  // Reference model and output recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      m_idx = 0;
      m_tsel = 0;
      for (int t = 0; t < 3; t++)
        for (int a = 0; a < 64; a++) tbl_m[t][a] = 4096;
      while (exp_d.size() > obs_d.size()) begin
        void'(exp_d.pop_back());
        void'(exp_l.pop_back());
      end
    end else begin
      if (out_valid && out_ready) begin
        obs_d.push_back(int'(out_data));
        obs_l.push_back(out_last);
      end
      if (in_valid && in_ready) begin
        if (m_idx == 0) m_tsel = (int'(in_tsel) < 3) ? int'(in_tsel) : 0;
        exp_d.push_back(qref(int'(in_data), tbl_m[m_tsel][m_idx]));
        exp_l.push_back(m_idx == 63);
        m_idx = (m_idx + 1) % 64;
      end
      if (tbl_wr_en && int'(tbl_wr_sel) < 3) tbl_m[tbl_wr_sel][tbl_wr_addr] = int'(tbl_wr_data);
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic put(input int d, input int t);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = 11'(d);
    in_tsel  = 2'(t);
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("put_timeout", 0, 1);
  endtask

  task automatic wr(input int sel, input int addr, input int data);
    tbl_wr_en   = 1'b1;
    tbl_wr_sel  = 2'(sel);
    tbl_wr_addr = 6'(addr);
    tbl_wr_data = 13'(data);
    @(posedge clk);
    #1;
    tbl_wr_en = 1'b0;
  endtask

  task automatic drain_cmp(input string tag);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_count"}, obs_d.size(), exp_d.size());
    n = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
    for (int i = rd; i < n; i++) begin
      chk($sformatf("%s_data[%0d]", tag, i), obs_d[i], exp_d[i]);
      chk($sformatf("%s_last[%0d]", tag, i), 32'(obs_l[i]), 32'(exp_l[i]));
    end
    rd = (obs_d.size() > exp_d.size()) ? obs_d.size() : exp_d.size();
  endtask

  task automatic chk_nz(input string tag, input int expv);
`ifdef JPQ_NZ_STATS_EN
    chk(tag, 32'(nz_count), expv);
`else
    chk(tag, 32'(nz_count), 0 * expv);
`endif
  endtask

  initial begin
    int base;
    int c[64];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tsel = '0; out_ready = 1'b1;
    tbl_wr_en = 1'b0; tbl_wr_sel = '0; tbl_wr_addr = '0; tbl_wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_nz_count", 32'(nz_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // Pass-through block of 100s with latency probe on the first three accepts.
    base = obs_d.size();
    put(100, 0); chk("lat_edge0", 32'(out_valid), 0);
    put(100, 0); chk("lat_edge1", 32'(out_valid), 0);
    put(100, 0); chk("lat_edge2", 32'(out_valid), 1);
    chk("lat_first_data", out_data, 100);
    for (int k = 3; k < 64; k++) put(100, 0);
    drain_cmp("t1");
    chk("t1_last63", 32'(obs_l[base + 63]), 1);
    chk("t1_last62", 32'(obs_l[base + 62]), 0);
    chk_nz("t1_nz", 64);

    // Q=16 in table 2: rounding ties away from zero.
    for (int a = 0; a < 64; a++) wr(2, a, 256);
    base = obs_d.size();
    put(100, 2); put(-24, 2); put(8, 2); put(-8, 2);
    for (int k = 4; k < 64; k++) put(int'($urandom_range(0, 2047)) - 1024, 3);
    drain_cmp("t2");
    chk("t2_100", obs_d[base + 0], 6);
    chk("t2_m24", obs_d[base + 1], -2);
    chk("t2_8", obs_d[base + 2], 1);
    chk("t2_m8", obs_d[base + 3], -1);

    // Saturation at both rails.
    wr(1, 0, 8191);
    base = obs_d.size();
    put(1023, 1);
    for (int k = 1; k < 64; k++) put(int'($urandom_range(0, 2047)) - 1024, 1);
    put(-1024, 1);
    for (int k = 1; k < 64; k++) put(int'($urandom_range(0, 2047)) - 1024, 1);
    drain_cmp("t3");
    chk("t3_satp", obs_d[base], 1023);
    chk("t3_satn", obs_d[base + 64], -1024);

    // Five-cycle downstream stall mid-block.
    fork
      begin
        for (int k = 0; k < 64; k++) put(int'($urandom_range(0, 2047)) - 1024, 1);
      end
      begin
        repeat (20) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 0);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    drain_cmp("t4");

    // Mid-block table-select change is ignored; next block picks table 2.
    base = obs_d.size();
    for (int k = 0; k < 64; k++) begin
      c[k] = int'($urandom_range(0, 2047)) - 1024;
      put(c[k], (k < 10) ? 0 : 2);
    end
    put(100, 2);
    for (int k = 1; k < 64; k++) put(int'($urandom_range(0, 2047)) - 1024, 0);
    drain_cmp("t5");
    chk("t5_keep_tbl0", obs_d[base + 20], c[20]);
    chk("t5_tbl2", obs_d[base + 64], 6);

    // Random tables, selects, backpressure and concurrent table writes.
    for (int a = 0; a < 64; a++) begin
      wr(0, a, int'($urandom_range(1, 8191)));
      wr(1, a, int'($urandom_range(1, 8191)));
    end
    wr(3, 0, 1);
    fork
      begin
        for (int k = 0; k < 192; k++)
          put(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 3)));
      end
      begin
        repeat (300) begin
          @(posedge clk);
          #1;
          out_ready   = ($urandom_range(0, 2) != 0);
          tbl_wr_en   = ($urandom_range(0, 5) == 0);
          tbl_wr_sel  = 2'($urandom_range(0, 3));
          tbl_wr_addr = 6'($urandom_range(0, 63));
          tbl_wr_data = 13'($urandom_range(1, 8191));
        end
        #1;
        out_ready = 1'b1;
        tbl_wr_en = 1'b0;
      end
    join
    drain_cmp("t6");

    // Reset at coefficient 30 discards in-flight data and restores tables.
    for (int k = 0; k < 30; k++) put(int'($urandom_range(0, 2047)) - 1024, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst2_out_valid", 32'(out_valid), 0);
    chk("rst2_out_last", 32'(out_last), 0);
    base = obs_d.size();
    for (int k = 0; k < 64; k++) begin
      c[k] = int'($urandom_range(0, 2047)) - 1024;
      if (k == 5) tbl_wr_en = 1'b0;
      if (k == 5) begin
        tbl_wr_sel = 2'd0; tbl_wr_addr = 6'd5; tbl_wr_data = 13'd2048; tbl_wr_en = 1'b1;
      end
      put(c[k], 0);
      tbl_wr_en = 1'b0;
    end
    drain_cmp("t7");
    chk("t7_old_on_collision", obs_d[base + 5], c[5]);
    chk("t7_last", 32'(obs_l[base + 63]), 1);

    // Block with exactly five non-zero results, the last on index 63.
    for (int k = 0; k < 64; k++) c[k] = 0;
    c[0] = 3; c[5] = 7; c[17] = -9; c[40] = 50; c[63] = -1;
    base = obs_d.size();
    for (int k = 0; k < 64; k++) put(c[k], 0);
    drain_cmp("t8");
    chk("t8_q2_round", obs_d[base + 5], 4);
    chk_nz("t8_nz", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpeg_quantizer_stream.md
Name: jpeg_quantizer_stream

Overview:
Streaming, parametrised quantizer for 8x8 DCT blocks. Takes one signed coefficient per cycle in raster order and multiplies it by a reciprocal (2^FRAC/Q) from a runtime-loadable table bank. It then rounds half away from zero and saturates the result. It sits between the 2D DCT and the zigzag/RLE stage and serves Y, Cb and Cr through per-block table selection, with valid/ready flow control.

Parameters:
IN_W, 11, signed input coefficient width
OUT_W, 11, signed quantized output width
RECIP_W, 13, unsigned reciprocal width (holds 4096 for Q=1)
FRAC, 12, fractional bits of reciprocal; result = (coef*recip) >> FRAC with rounding
NUM_TABLES, 3, number of 64-entry reciprocal tables (0=Y, 1=Cb, 2=Cr)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  input coefficient valid
in_ready  out  1  block can accept input this cycle
in_data  in  IN_W  signed DCT coefficient
in_tsel  in  $clog2(NUM_TABLES)  table select; sampled only on the first coefficient of a block
out_valid  out  1  output coefficient valid
out_ready  in  1  downstream accepts output
out_data  out  OUT_W  signed quantized coefficient
out_last  out  1  marks the 64th coefficient of a block
tbl_wr_en  in  1  table write strobe
tbl_wr_sel  in  $clog2(NUM_TABLES)  table to write
tbl_wr_addr  in  6  raster index 0..63
tbl_wr_data  in  RECIP_W  reciprocal value
nz_count  out  7  non-zero outputs in the last block (JPQ_NZ_STATS_EN only)

Behaviour:
- Reset: out_valid=0, out_data=0, out_last=0, nz_count=0, in_idx=0, every pipeline valid bit cleared. All table entries reset to 2^FRAC (Q=1, pass-through).
- Pipeline: 3 stages. S1 registers the coefficient, index and reciprocal. S2 does the signed multiply, product width IN_W+RECIP_W+1, with the reciprocal zero-extended. S3 rounds, saturates and registers out_data.
- Latency: in_valid&in_ready at cycle N gives out_valid at N+3 when there is no stall.
- Flow control: global advance = out_ready | ~out_valid. in_ready equals advance. When advance=0, every stage holds. No bubbles are inserted; back-to-back throughput is 1 coefficient per cycle.
- Index counter in_idx (6b):
  - Increments on each accepted input and wraps 63->0.
  - in_tsel is latched into blk_tsel when a coefficient is accepted with in_idx==0. That value holds for the whole block.
  - A mid-block change of in_tsel is ignored.
- out_last=1 exactly when the output coefficient's index is 63.
- Rounding:
  - Take mag=|product|, r = (mag + 2^(FRAC-1)) >> FRAC, then reapply the sign.
  - Ties round away from zero. A zero product gives 0.
- Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Table writes:
  - A write lands at the clock edge and is visible to S1 lookups from the next cycle.
  - A same-cycle write and lookup to the same entry returns the old value.
  - Writes are accepted regardless of stall state.
- tbl_wr_sel >= NUM_TABLES: the write is ignored.
- in_tsel >= NUM_TABLES: table 0 is used.
- Reset mid-block discards all in-flight data. The next accepted coefficient is index 0.

Optional Feature:
JPQ_NZ_STATS_EN:
- Defined:
  - An internal 7b counter counts S3 outputs with out_data!=0 per block.
  - On the cycle the out_last output is accepted (out_valid&out_ready), nz_count loads the final count, including that coefficient. The counter then clears.
  - nz_count holds until the next block completes.
- Undefined: nz_count is tied to 0 and no counter logic exists.

Test Plan:
- Reset tables, stream 64 coefs of value 100 with tsel=0 -> 64 outputs of 100, out_last only on 64th, first out_valid 3 cycles after first accept.
- Write table 2 all 256 (Q=16), tsel=2, coefs 100, -24, 8, -8 -> 6, -2, 1, -1 (round half away from zero).
- Table 1 entry 0 = 8191, coef 1023 -> saturates to 1023; coef -1024 -> -1024.
- Full block streaming with out_ready held low 5 cycles mid-block -> no data lost or duplicated, in_ready low during stall, order preserved.
- Toggle in_tsel from 0 to 2 at coefficient 10 -> whole block still uses table 0; next block (tsel=2 at idx 0) uses table 2.
- Assert rst at coefficient 30 then resend a block -> no stale outputs, out_last on new block's 64th; with JPQ_NZ_STATS_EN, block of 5 non-zero results -> nz_count=5 after last handshake.
